// File: rtl/rot_shift_sequencer_if.sv
// rtl/rot_shift_sequencer_if.sv - request/result bundle between control unit and rotate/shift sequencer
interface rot_shift_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a_in, b_in,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, op, a_in, b_in,
    output ready, busy, done, result
  );
endinterface

// File: rtl/rot_shift_sequencer.sv
// rtl/rot_shift_sequencer.sv - iterative one-bit-per-clock ROL/ROR/SHL/SHR/SHRA unit
module rot_shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic                  clock,
  input logic                  clear,
  rot_shift_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ROL  = 3'd0;
  localparam logic [2:0] OP_ROR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_SHRA = 3'd4;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] acc_step;
  logic             op_valid;
  logic             unused_b_hi;

  // Only the low CNT_W bits of the amount matter: counts are taken mod WIDTH.
  assign unused_b_hi = ^bus.b_in[WIDTH-1:CNT_W];
  assign op_valid    = (op_r <= OP_SHRA);

  always_comb begin
    acc_step = acc;
    case (op_r)
      OP_ROL:  acc_step = {acc[WIDTH-2:0], acc[WIDTH-1]};
      OP_ROR:  acc_step = {acc[0], acc[WIDTH-1:1]};
      OP_SHL:  acc_step = {acc[WIDTH-2:0], 1'b0};
      OP_SHR:  acc_step = {1'b0, acc[WIDTH-1:1]};
      OP_SHRA: acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_step = acc;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
      op_r  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // DONE also accepts a start so back-to-back issue costs no bubble.
          if (bus.start) begin
            acc   <= bus.a_in;
            count <= bus.b_in[CNT_W-1:0];
            op_r  <= bus.op;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if ((count != '0) && op_valid) begin
            acc   <= acc_step;
            count <= count - 1'b1;
          end else begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = acc;
  assign bus.busy   = (state == S_RUN);
  assign bus.ready  = !bus.busy;
  assign bus.done   = (state == S_DONE);

endmodule

// File: tb/tb_rot_shift_sequencer.sv
// tb/tb_rot_shift_sequencer.sv - self-checking bench for rot_shift_sequencer
module tb_rot_shift_sequencer;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rot_shift_sequencer_if #(.WIDTH(32)) bus ();

  rot_shift_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference: whole-word arithmetic on the amount mod 32.
  function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    int n;
    n = int'(b % 32);
    case (o)
      3'd0: return (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      3'd1: return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      3'd2: return a << n;
      3'd3: return a >> n;
      3'd4: return 32'($signed(a) >>> n);
      default: return a;
    endcase
  endfunction

  function automatic int model_edges(input logic [2:0] o, input logic [31:0] b);
    return ((o <= 3'd4) ? int'(b % 32) : 0) + 1;
  endfunction

  task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a_in  = $urandom;
    bus.b_in  = $urandom;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    drive_start(o, a, b);
  endtask

  // Counts edges after the accepting edge until done is seen; optionally pulses a stray start.
  task automatic wait_done(input int pulse_at, output int edges, output bit timed_out);
    edges     = 0;
    timed_out = 1'b1;
    while (edges < 100) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (bus.done) begin
        timed_out = 1'b0;
        break;
      end
      if (edges == pulse_at) begin
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
      end else if (edges == pulse_at + 1) begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a_in  = 32'hDEADBEEF;
    bus.b_in  = 32'd3;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.result !== 32'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: result=%h done=%b busy=%b ready=%b, want 0/0/0/1",
               bus.result, bus.done, bus.busy, bus.ready);
    end
    bus.start = 1'b0;
    clear     = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: busy=%b ready=%b, want 0/1", bus.busy, bus.ready);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops  [8] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd4, 3'd3, 3'd2, 3'd2};
    logic [31:0] as   [8] = '{32'h80000001, 32'h00000001, 32'h12345678, 32'h12345678,
                              32'h80000000, 32'h80000000, 32'h0000000F, 32'h0000000F};
    logic [31:0] bs   [8] = '{32'd1, 32'd4, 32'd33, 32'd32, 32'd31, 32'd31, 32'd28, 32'd32};
    logic [31:0] exp_r[8] = '{32'h00000003, 32'h10000000, 32'h2468ACF0, 32'h12345678,
                              32'hFFFFFFFF, 32'h00000001, 32'hF0000000, 32'h0000000F};
    int          exp_e[8] = '{2, 5, 2, 1, 32, 32, 29, 1};
    int edges;
    bit to;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(-5, edges, to);
      checks++;
      if (to || edges != exp_e[i] || bus.result !== exp_r[i]) begin
        errors++;
        $display("FAIL directed_%0d: result=%h edges=%0d timeout=%b, want result=%h edges=%0d",
                 i, bus.result, edges, to, exp_r[i], exp_e[i]);
      end
      @(negedge clock);
      checks++;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.result !== exp_r[i]) begin
        errors++;
        $display("FAIL done_pulse_%0d: done=%b ready=%b result=%h, want 0/1/%h",
                 i, bus.done, bus.ready, bus.result, exp_r[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    int edges;
    bit to;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd32 * $urandom_range(0, 3) : $urandom;
      issue(o, a, b);
      wait_done(-5, edges, to);
      checks++;
      if (to || edges != model_edges(o, b) || bus.result !== model_result(o, a, b)) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h edges=%0d, want %h edges=%0d",
                 i, o, a, b, bus.result, edges, model_result(o, a, b), model_edges(o, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    bit to;
    issue(3'd0, 32'h80000001, 32'd1);
    wait_done(-5, edges, to);
    checks++;
    if (to || bus.result !== 32'h00000003) begin
      errors++;
      $display("FAIL b2b_first: result=%h timeout=%b, want 00000003", bus.result, to);
    end
    drive_start(3'd1, 32'hF0000000, 32'd4);
    checks++;
    if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble: busy=%b ready=%b, want 1/0", bus.busy, bus.ready);
    end
    wait_done(-5, edges, to);
    checks++;
    if (to || edges != 5 || bus.result !== 32'h0F000000) begin
      errors++;
      $display("FAIL b2b_second: result=%h edges=%0d, want 0F000000 edges=5", bus.result, edges);
    end
  endtask

  task automatic test_ignore_busy();
    int edges;
    bit to;
    issue(3'd0, 32'h12345678, 32'd10);
    wait_done(3, edges, to);
    checks++;
    if (to || edges != 11 || bus.result !== model_result(3'd0, 32'h12345678, 32'd10)) begin
      errors++;
      $display("FAIL ignore_busy: result=%h edges=%0d, want %h edges=11",
               bus.result, edges, model_result(3'd0, 32'h12345678, 32'd10));
    end
  endtask

  task automatic test_invalid_op();
    int edges;
    bit to;
    issue(3'd7, 32'hCAFEF00D, 32'd7);
    wait_done(-5, edges, to);
    checks++;
    if (to || edges != 1 || bus.result !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL invalid_op: result=%h edges=%0d, want cafef00d edges=1", bus.result, edges);
    end
  endtask

  task automatic test_abort();
    int edges;
    bit to;
    issue(3'd0, 32'hA5A5A5A5, 32'd20);
    repeat (10) @(posedge clock);
    #3;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_running: busy=%b, want 1", bus.busy);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (bus.result !== 32'd0 || bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: result=%h busy=%b ready=%b done=%b, want 0/0/1/0",
               bus.result, bus.busy, bus.ready, bus.done);
    end
    @(negedge clock);
    clear = 1'b0;
    issue(3'd1, 32'h00000001, 32'd4);
    wait_done(-5, edges, to);
    checks++;
    if (to || edges != 5 || bus.result !== 32'h10000000) begin
      errors++;
      $display("FAIL abort_restart: result=%h edges=%0d, want 10000000 edges=5", bus.result, edges);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_busy();
    test_invalid_op();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rot_shift_sequencer.md
Name: rot_shift_sequencer

Overview:
- Multi-cycle iterative rotate/shift unit for the CPU datapath ALU: performs ROL, ROR, SHL, SHR and SHRA one bit position per clock.
- Replaces wide single-cycle rotate/shift logic when area matters.
- The control unit issues a start pulse with operands and opcode, then waits for done. The result feeds the ALU output mux into Z.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2.
- CNT_W, 5, width of the shift-count register; must equal log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous active-high reset.
- start  input  1  request pulse; sampled only when ready=1.
- op  input  3  000 ROL, 001 ROR, 010 SHL, 011 SHR, 100 SHRA, others pass-through.
- a_in  input  WIDTH  value to rotate or shift.
- b_in  input  WIDTH  shift amount; only b_in[CNT_W-1:0] is used (amount = B mod WIDTH).
- ready  output  1  high in IDLE and DONE; a start is accepted in either state.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- result  output  WIDTH  accumulator; holds the last result until the next accepted start.

Behaviour:
- Reset (clear=1, asynchronous):
  - State goes to IDLE; acc, count and op_r go to 0.
  - Outputs: result=0, done=0, busy=0, ready=1.
  - Reset dominates start on the same edge.
- States:
  - IDLE: on start, latch acc<=a_in, count<=b_in[CNT_W-1:0] and op_r<=op, then go to RUN.
  - RUN:
    - If count != 0 and op_r is valid: apply one step to acc, count<=count-1, stay in RUN.
    - If count == 0 or op_r is invalid: go to DONE and leave acc unchanged.
  - DONE:
    - done=1 for exactly this one cycle.
    - If start is high: latch new operands and go to RUN (back-to-back issue, no bubble).
    - Otherwise go to IDLE.
- Step operations on acc, one per RUN edge:
  - ROL: {acc[W-2:0], acc[W-1]}
  - ROR: {acc[0], acc[W-1:1]}
  - SHL: {acc[W-2:0], 0}
  - SHR: {0, acc[W-1:1]}
  - SHRA: {acc[W-1], acc[W-1:1]}
- Latency: done is high in the cycle after n+1 rising edges following the edge that accepted start (n = amount).
  - Amount 0 (including b_in = WIDTH or any multiple of it) gives done after 1 edge with result = a_in.
  - Invalid opcodes behave as amount 0 regardless of b_in.
- Shift amounts are also taken mod WIDTH, so SHL by 32 returns a_in unchanged. This is intentional; the ISA defines counts mod 32.
- start while busy=1 is ignored: no latch, no queue, no error flag.
- a_in, b_in and op are don't-care except on the accepting edge.
- result equals acc at all times. Intermediate values are visible during RUN; consumers must qualify with done.
- clear asserted mid-RUN aborts the operation. After clear releases, the next start behaves normally.
- ready and busy are mutually exclusive and always cover the state: ready = !busy.

Test Plan:
- ROL, a_in=0x80000001, b_in=1 → done after 2 edges, result=0x00000003; ROR, a_in=0x00000001, b_in=4 → done after 5 edges, result=0x10000000.
- ROL, a_in=0x12345678, b_in=33 (amount 1) → result=0x2468ACF0, 2 edges; b_in=32 → result=0x12345678, done after 1 edge.
- SHRA, a_in=0x80000000, b_in=31 → result=0xFFFFFFFF after 32 edges; SHR with the same operands → 0x00000001; SHL, a_in=0x0000000F, b_in=28 → 0xF0000000.
- Back-to-back: hold start high in the DONE cycle with new operands (ROR, 0xF0000000, 4) → no IDLE cycle, second done 5 edges later, result=0x0F000000.
- Mid-operation start: start pulsed while busy with different operands → ignored, original result unchanged; op=111, b_in=7 → result=a_in, done after 1 edge.
- Reset abort: assert clear asynchronously mid-RUN with count=10 → immediately result=0, busy=0, ready=1, done=0; a fresh start afterwards completes correctly.
